tag_pool: RTL and testbench

TAG_POOL -- requirements
Module: tag_pool

---
 rtl/tag_pool.sv | 148 ++++++++++++++
 tb/tb_tag_pool.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tag_pool.sv
// Tag allocator: hands out up to NumGetPorts unused tags per cycle and accepts NumFreePorts releases.
// Optional illegal-free detection is enabled with `define TAG_POOL_FREE_CHECK_EN.
module tag_pool #(
  parameter int unsigned NumTags      = 8,
  parameter int unsigned NumGetPorts  = 2,
  parameter int unsigned NumFreePorts = 2,
  parameter bit          RoundRobin   = 1'b0,
  localparam int unsigned TagWidth    = $clog2(NumTags),
  localparam int unsigned CntWidth    = $clog2(NumTags + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumFreePorts-1:0]          free_i,
  input  logic [NumFreePorts*TagWidth-1:0] free_tag_i,
  input  logic [NumGetPorts-1:0]           get_i,
  output logic [NumGetPorts-1:0]           valid_o,
  output logic [NumGetPorts*TagWidth-1:0]  tag_o,
  output logic [CntWidth-1:0]              num_free_o,
  output logic                             error_o
);
  typedef logic [TagWidth-1:0] tag_t;
  typedef logic [TagWidth:0]   tag_ext_t;
  localparam tag_ext_t NumTagsExt = tag_ext_t'(NumTags);

  logic [NumTags-1:0]  used_q, used_d;
  tag_t                rr_q, rr_d, rr_cand;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  tag_t                ord_idx [NumTags];
  logic [NumTags-1:0]  ord_free;
  tag_t                tag_sel [NumGetPorts];
  logic [NumGetPorts-1:0] valid_sel, acc;
  logic [NumTags-1:0]  get_mask, free_mask;
  logic [CntWidth-1:0] seen;
  tag_t                ft;
  logic                in_range;

  // Search slot gi holds tag (rr_q + gi) mod NumTags; rr_q is always 0 in lowest-first mode.
  genvar gi;
  generate
    for (gi = 0; gi < NumTags; gi++) begin : g_order
      tag_ext_t sum;
      assign sum          = tag_ext_t'(rr_q) + tag_ext_t'(gi);
      assign ord_idx[gi]  = (sum >= NumTagsExt) ? tag_t'(sum - NumTagsExt) : tag_t'(sum);
      assign ord_free[gi] = ~used_q[ord_idx[gi]];
    end
  endgenerate

  // Port p is offered the (p+1)-th unused tag in search order.
  always_comb begin
    seen      = '0;
    valid_sel = '0;
    for (int p = 0; p < NumGetPorts; p++) tag_sel[p] = '0;
    for (int k = 0; k < NumTags; k++) begin
      for (int p = 0; p < NumGetPorts; p++) begin
        if (ord_free[k] && (seen == CntWidth'(p))) begin
          valid_sel[p] = 1'b1;
          tag_sel[p]   = ord_idx[k];
        end
      end
      seen = seen + CntWidth'(ord_free[k]);
    end
  end

  generate
    for (gi = 0; gi < NumGetPorts; gi++) begin : g_port
      assign valid_o[gi]                     = valid_sel[gi];
      assign tag_o[gi*TagWidth +: TagWidth]  = tag_sel[gi];
      assign acc[gi]                         = get_i[gi] & valid_sel[gi];
    end
  endgenerate

  // Highest accepted port holds the last tag in search order, so it sets the next start point.
  always_comb begin
    get_mask = '0;
    rr_cand  = rr_q;
    for (int p = 0; p < NumGetPorts; p++) begin
      if (acc[p]) begin
        get_mask[tag_sel[p]] = 1'b1;
        rr_cand = (tag_sel[p] == tag_t'(NumTags - 1)) ? '0 : tag_sel[p] + tag_t'(1);
      end
    end
  end

`ifdef TAG_POOL_FREE_CHECK_EN
  logic bad_free, dup, err_q;

  always_comb begin
    free_mask = '0;
    bad_free  = 1'b0;
    ft        = '0;
    in_range  = 1'b0;
    dup       = 1'b0;
    for (int f = 0; f < NumFreePorts; f++) begin
      ft       = free_tag_i[f*TagWidth +: TagWidth];
      in_range = tag_ext_t'(ft) < NumTagsExt;
      dup      = 1'b0;
      for (int j = 0; j < f; j++) begin
        if (free_i[j] && (free_tag_i[j*TagWidth +: TagWidth] == ft)) dup = 1'b1;
      end
      if (free_i[f]) begin
        if (in_range && used_q[ft] && !dup) free_mask[ft] = 1'b1;
        else                                bad_free      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)       err_q <= 1'b0;
    else if (bad_free) err_q <= 1'b1;
  end

  assign error_o = err_q;
`else
  always_comb begin
    free_mask = '0;
    ft        = '0;
    in_range  = 1'b0;
    for (int f = 0; f < NumFreePorts; f++) begin
      ft       = free_tag_i[f*TagWidth +: TagWidth];
      in_range = tag_ext_t'(ft) < NumTagsExt;
      if (free_i[f] && in_range) free_mask[ft] = 1'b1;
    end
  end

  assign error_o = 1'b0;
`endif

  // Count derived from the next bitmap so it can never drift from popcount.
  assign used_d = (used_q & ~free_mask) | get_mask;
  assign cnt_d  = CntWidth'(NumTags) - CntWidth'($countones(used_d));
  assign rr_d   = RoundRobin ? rr_cand : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      used_q <= '0;
      rr_q   <= '0;
      cnt_q  <= CntWidth'(NumTags);
    end else begin
      used_q <= used_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign num_free_o = cnt_q;

endmodule

// File: tb/tb_tag_pool.sv
// Scoreboard bench for tag_pool: lowest-first and round-robin instances driven with identical stimulus.
module tb_tag_pool;
  logic       clk;
  logic       rst_n;
  logic [1:0] get;
  logic [1:0] free;
  logic [5:0] ftag;

  logic [1:0] valid_a, valid_b;
  logic [5:0] tag_a, tag_b;
  logic [3:0] nfree_a, nfree_b;
  logic       err_a, err_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  tag_pool #(.NumTags(8), .NumGetPorts(2), .NumFreePorts(2), .RoundRobin(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .free_i(free), .free_tag_i(ftag), .get_i(get),
    .valid_o(valid_a), .tag_o(tag_a), .num_free_o(nfree_a), .error_o(err_a)
  );

  tag_pool #(.NumTags(8), .NumGetPorts(2), .NumFreePorts(2), .RoundRobin(1'b1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .free_i(free), .free_tag_i(ftag), .get_i(get),
    .valid_o(valid_b), .tag_o(tag_b), .num_free_o(nfree_b), .error_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [1:0] v;
    logic [5:0] tags;
    logic [3:0] nf;
    logic       e;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_used [2];
  logic [2:0] m_rr   [2];
  logic       m_err  [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Walk the pool from the start pointer and hand out the first two unused tags.
  function automatic void offers(input logic [7:0] used, input logic [2:0] rr,
                                 output logic [1:0] v, output logic [2:0] t0, output logic [2:0] t1);
    int n = 0;
    v = 2'b00; t0 = 3'd0; t1 = 3'd0;
    for (int k = 0; k < 8; k++) begin
      int idx = (int'(rr) + k) % 8;
      if (!used[idx]) begin
        if (n == 0) begin v[0] = 1'b1; t0 = 3'(idx); end
        else if (n == 1) begin v[1] = 1'b1; t1 = 3'(idx); end
        n++;
      end
    end
  endfunction

  task automatic model_clock(input int i, input logic r, input logic [1:0] g, input logic [1:0] f,
                             input logic [2:0] t0, input logic [2:0] t1);
    logic [1:0] v;
    logic [2:0] o0, o1, last;
    logic [7:0] nu;
    logic [2:0] tq;
    logic       any;
    if (!r) begin
      m_used[i] = 8'h00; m_rr[i] = 3'd0; m_err[i] = 1'b0;
      return;
    end
    offers(m_used[i], m_rr[i], v, o0, o1);
    nu = m_used[i];
    for (int q = 0; q < 2; q++) begin
      tq = (q == 0) ? t0 : t1;
      if (f[q]) begin
`ifdef TAG_POOL_FREE_CHECK_EN
        if (!m_used[i][tq] || (q == 1 && f[0] && t0 == t1)) m_err[i] = 1'b1;
        else nu[tq] = 1'b0;
`else
        nu[tq] = 1'b0;
`endif
      end
    end
    any = 1'b0; last = 3'd0;
    if (g[0] && v[0]) begin nu[o0] = 1'b1; any = 1'b1; last = o0; end
    if (g[1] && v[1]) begin nu[o1] = 1'b1; any = 1'b1; last = o1; end
    m_used[i] = nu;
    if (i == 1 && any) m_rr[i] = last + 3'd1;
  endtask

  task automatic cycle(input logic r, input logic [1:0] g, input logic [1:0] f,
                       input logic [2:0] t0, input logic [2:0] t1);
    exp_t e;
    logic [1:0] v;
    logic [2:0] o0, o1;
    rst_n = r; get = g; free = f; ftag = {t1, t0};
    for (int i = 0; i < 2; i++) begin
      offers(m_used[i], m_rr[i], v, o0, o1);
      e.inst = i; e.v = v; e.tags = {o1, o0};
      e.nf = 4'(8 - $countones(m_used[i])); e.e = m_err[i];
      exp_q.push_back(e);
    end
    @(negedge clk);
    $display("cyc %0d rst_n=%b get=%b free=%b ftag=(%0d,%0d) | lf v=%b t=(%0d,%0d) nf=%0d e=%b | rr v=%b t=(%0d,%0d) nf=%0d e=%b",
             cyc, r, g, f, t0, t1, valid_a, tag_a[2:0], tag_a[5:3], nfree_a, err_a,
             valid_b, tag_b[2:0], tag_b[5:3], nfree_b, err_b);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        chk("lf_valid", 32'(valid_a), 32'(e.v));
        chk("lf_tags",  32'(tag_a),   32'(e.tags));
        chk("lf_nfree", 32'(nfree_a), 32'(e.nf));
        chk("lf_err",   32'(err_a),   32'(e.e));
      end else begin
        chk("rr_valid", 32'(valid_b), 32'(e.v));
        chk("rr_tags",  32'(tag_b),   32'(e.tags));
        chk("rr_nfree", 32'(nfree_b), 32'(e.nf));
        chk("rr_err",   32'(err_b),   32'(e.e));
      end
    end
    @(posedge clk);
    model_clock(0, r, g, f, t0, t1);
    model_clock(1, r, g, f, t0, t1);
    cyc++;
    #1;
  endtask

  initial begin
    logic [1:0] rg, rf;
    rst_n = 1'b0; get = 2'b00; free = 2'b00; ftag = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    model_clock(0, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
    model_clock(1, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0);

    // Requests during reset are dropped.
    cycle(1'b0, 2'b11, 2'b00, 3'd0, 3'd0);
    chk("reset_valid", 32'(valid_a), 32'h3);
    chk("reset_tags",  32'(tag_a),   32'(6'b001_000));
    chk("reset_nfree", 32'(nfree_a), 32'd8);
    chk("reset_err",   32'(err_a),   32'd0);

    // Fill the pool two at a time.
    repeat (4) cycle(1'b1, 2'b11, 2'b00, 3'd0, 3'd0);
    chk("full_valid", 32'(valid_a), 32'h0);
    chk("full_nfree", 32'(nfree_a), 32'd0);

    // Free into a full pool: nothing allocated, tag reappears next cycle.
    cycle(1'b1, 2'b11, 2'b01, 3'd5, 3'd0);
    chk("refree_valid", 32'(valid_a), 32'h1);
    chk("refree_tag0",  32'(tag_a[2:0]), 32'd5);
    chk("refree_nfree", 32'(nfree_a), 32'd1);

    // Gap on port 0 while tag 3 is released in the same cycle.
    cycle(1'b1, 2'b00, 2'b01, 3'd2, 3'd0);
    cycle(1'b1, 2'b10, 2'b01, 3'd3, 3'd0);
    chk("gap_tag0",  32'(tag_a[2:0]), 32'd2);
    chk("gap_tag1",  32'(tag_a[5:3]), 32'd3);
    chk("gap_nfree", 32'(nfree_a), 32'd2);

    for (int n = 0; n < 30; n++) begin
      rg = 2'($urandom_range(0, 3));
      rf = 2'($urandom_range(0, 3));
      cycle(1'b1, rg, rf, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    // Release of a tag that is not in use.
    cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b00, 2'b01, 3'd6, 3'd0);
    cycle(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);
`ifdef TAG_POOL_FREE_CHECK_EN
    chk("illegal_err", 32'(err_a), 32'd1);
`else
    chk("illegal_err", 32'(err_a), 32'd0);
`endif
    chk("illegal_nfree", 32'(nfree_a), 32'd8);

    // Round-robin skips the just-freed tag and wraps at the top.
    cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b11, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b00, 2'b01, 3'd0, 3'd0);
    chk("rr_next_tag", 32'(tag_b[2:0]), 32'd2);
    chk("lf_next_tag", 32'(tag_a[2:0]), 32'd0);
    repeat (6) cycle(1'b1, 2'b01, 2'b00, 3'd0, 3'd0);
    chk("rr_wrap_valid", 32'(valid_b), 32'h1);
    chk("rr_wrap_tag",   32'(tag_b[2:0]), 32'd0);

    // Reset in the middle of traffic with five tags held.
    cycle(1'b0, 2'b00, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b11, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b11, 2'b00, 3'd0, 3'd0);
    cycle(1'b1, 2'b01, 2'b00, 3'd0, 3'd0);
    chk("mid_nfree_before", 32'(nfree_a), 32'd3);
    cycle(1'b0, 2'b11, 2'b11, 3'd1, 3'd2);
    chk("mid_nfree", 32'(nfree_a), 32'd8);
    chk("mid_tags",  32'(tag_a),   32'(6'b001_000));
    chk("mid_err",   32'(err_a),   32'd0);
    cycle(1'b1, 2'b00, 2'b00, 3'd0, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
